mul_pp_gen: RTL and testbench
=============================

// Module: mul_pp_gen
// PURPOSE
//   Iterative partial-product generator for the multiplier datapath in core/alu/mul.
//   - Accepts two XLEN-bit operands, signed or unsigned, over a valid/ready handshake.
//   - Over CHUNK cycles it builds N partial products of 2*XLEN bits each.
//   - It presents them, with their sign already applied, directly to adder_tree.
//   - The sum of the N outputs, taken modulo 2^(2*XLEN), equals a*b.
// PARAMETERS
//   XLEN   64   operand width
//   N      8    number of partial products (adder_tree N); XLEN % N == 0
//   CHUNK  XLEN/N (localparam)   bits of b per partial product = GEN cycles
// PORTS
//   clk        in   1           clock, rising edge
//   rst_n      in   1           asynchronous active-low reset
//   in_valid   in   1           operand request valid
//   in_ready   out  1           block can accept operands
//   a          in   XLEN        multiplicand
//   b          in   XLEN        multiplier
//   is_signed  in   1           1: a and b are two's complement; 0: unsigned
//   out_valid  out  1           pp_out holds a complete set
//   out_ready  in   1           downstream consumes pp_out
//   pp_out     out  N*2*XLEN    pp i = pp_out[2*XLEN*i +: 2*XLEN], fed to adder_tree in[i]
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE, accumulators=0, cnt=0, neg=0.
//     Outputs: in_ready=1, out_valid=0, pp_out=0.
//     A reset mid-GEN or mid-DONE discards the operation; no output is produced.
//   FSM states: IDLE -> GEN -> DONE -> IDLE.
//     IDLE: in_ready=1. On in_valid&&in_ready, latch on the same edge:
//       ma = |a|, mb = |b|, neg = a[XLEN-1]^b[XLEN-1] when is_signed; otherwise ma=a, mb=b, neg=0.
//       Zero all accumulators, cnt=0, go to GEN.
//       |x| is the XLEN-bit unsigned magnitude; -2^(XLEN-1) maps to 2^(XLEN-1) without overflow.
//     GEN: in_ready=0, out_valid=0. Each edge, for every i in 0..N-1 in parallel:
//       acc[i] += mb[CHUNK*i+cnt] ? (ma << (CHUNK*i+cnt)) : 0
//       Arithmetic is 2*XLEN bits wide, zero-extended, and cannot overflow.
//       cnt increments each edge. On the edge where cnt==CHUNK-1, go to DONE.
//     DONE: out_valid=1, in_ready=0.
//       pp_out[i] = neg ? (~acc[i] + 1) : acc[i], truncated to 2*XLEN bits.
//       Because each pp is negated individually, the modular sum equals -(|a|*|b|).
//       On out_valid&&out_ready, go to IDLE on that edge.
//       While out_ready=0, state, pp_out and out_valid hold unchanged.
//   Latency: accept edge E0 -> out_valid high after edge E_CHUNK (CHUNK cycles).
//   Throughput: one operation per CHUNK+2 cycles minimum.
//     There is no overlap: the next accept happens in IDLE after the DONE handshake.
//   in_valid while in GEN or DONE is ignored; the operands must be held by the upstream.
//   pp_out is defined only while out_valid=1. After DONE->IDLE it may keep stale values.
//   Zero operands: all pp=0, including the neg=1 case (-0 = 0).
// TESTING  (N=8, XLEN=64; S = sum of pp_out mod 2^128, checked against a bench-side adder_tree)
//   1. Unsigned a=3, b=5 -> out_valid exactly 8 cycles after accept.
//      pp0=15, pp1..7=0, S=15.
//   2. Unsigned a=1, b=0xFFFF_FFFF_FFFF_FFFF -> pp_i = 0xFF<<(8*i), S=0x0000..FFFF_FFFF_FFFF_FFFF.
//   3. Signed a=-3, b=5 -> pp0=2^128-15, others 0, S=0xFFFF..FFF1.
//      Signed a=b=-2^63 -> S=2^126.
//   4. Backpressure: hold out_ready=0 for 5 cycles in DONE.
//      -> out_valid=1 and pp_out stable throughout; in_ready=0; in_valid pulses are ignored.
//      Handshake -> in_ready=1 on the next cycle.
//   5. Reset mid-GEN: assert rst_n=0 at cnt=4.
//      -> out_valid=0 and in_ready=1 immediately (async), pp_out=0.
//      A new request after release produces a correct result.
//   6. Random back-to-back: 200 random signed/unsigned pairs with random out_ready.
//      -> S == a*b mod 2^128 for every pair, in order, with none dropped or duplicated.

Source files
------------

// File: rtl/mul_pp_gen.sv
// Iterative signed/unsigned partial-product generator feeding adder_tree; CHUNK cycles accept->out_valid.
// Backpressure: DONE holds pp_out/out_valid until out_ready; in_ready only in IDLE, no overlap.
module mul_pp_gen #(
  parameter int XLEN = 64,
  parameter int N    = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [XLEN-1:0]       a,
  input  logic [XLEN-1:0]       b,
  input  logic                  is_signed,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [N*2*XLEN-1:0]   pp_out
);

  localparam int CHUNK = XLEN / N;
  localparam int CW    = (CHUNK > 1) ? $clog2(CHUNK) : 1;
  localparam int PW    = 2 * XLEN;

  typedef enum logic [1:0] {IDLE, GEN, DONE} state_t;

  state_t                 state, state_nxt;
  logic [XLEN-1:0]        ma, mb;
  logic [XLEN-1:0]        a_mag, b_mag;
  logic                   neg;
  logic [CW-1:0]          cnt;
  logic [N-1:0][PW-1:0]   acc;
  logic [N-1:0][PW-1:0]   addend;
  logic [N-1:0]           sel;
  logic                   accept;
  logic                   last;

  assign accept = in_valid && in_ready;
  assign last   = (cnt == CW'(CHUNK - 1));

  // Two's-complement magnitude; the most negative value maps to 2^(XLEN-1) in XLEN bits.
  assign a_mag = (is_signed && a[XLEN-1]) ? (~a + 1'b1) : a;
  assign b_mag = (is_signed && b[XLEN-1]) ? (~b + 1'b1) : b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = GEN;
      end
      GEN: begin
        if (last) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Lane i consumes bit (CHUNK*i + cnt) of mb, so all lanes step through their chunk together.
  for (genvar gi = 0; gi < N; gi++) begin : g_lane
    assign sel[gi]    = |(mb[CHUNK*gi +: CHUNK] & (CHUNK'(1) << cnt));
    assign addend[gi] = sel[gi] ? (({{XLEN{1'b0}}, ma} << (CHUNK*gi)) << cnt) : '0;
    assign pp_out[PW*gi +: PW] = neg ? (~acc[gi] + 1'b1) : acc[gi];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ma  <= '0;
      mb  <= '0;
      neg <= 1'b0;
      cnt <= '0;
      acc <= '0;
    end else if (accept) begin
      ma  <= a_mag;
      mb  <= b_mag;
      neg <= is_signed && (a[XLEN-1] ^ b[XLEN-1]);
      cnt <= '0;
      acc <= '0;
    end else if (state == GEN) begin
      for (int i = 0; i < N; i++) begin
        acc[i] <= acc[i] + addend[i];
      end
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_mul_pp_gen.sv
// Bench for mul_pp_gen: directed cases, backpressure, mid-operation reset and random traffic.
module tb_mul_pp_gen;

  localparam int XLEN = 64;
  localparam int N    = 8;
  localparam int PW   = 2 * XLEN;
  localparam int CH   = XLEN / N;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [XLEN-1:0]   a = '0;
  logic [XLEN-1:0]   b = '0;
  logic              is_signed = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [N*PW-1:0]   pp_out;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mul_pp_gen #(.XLEN(XLEN), .N(N)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .is_signed(is_signed), .out_valid(out_valid),
    .out_ready(out_ready), .pp_out(pp_out)
  );

  function automatic logic [PW-1:0] pp_of(input logic [N*PW-1:0] v, input int i);
    return v[PW*i +: PW];
  endfunction

  function automatic logic [PW-1:0] sum_pp(input logic [N*PW-1:0] v);
    logic [PW-1:0] s = '0;
    for (int i = 0; i < N; i++) s = s + v[PW*i +: PW];
    return s;
  endfunction

  // Exact product of the operands as signed or unsigned integers, mod 2^PW.
  function automatic logic [PW-1:0] ref_prod(input logic [XLEN-1:0] oa, ob, input logic os);
    logic [PW-1:0] ea, eb;
    ea = os ? {{XLEN{oa[XLEN-1]}}, oa} : {{XLEN{1'b0}}, oa};
    eb = os ? {{XLEN{ob[XLEN-1]}}, ob} : {{XLEN{1'b0}}, ob};
    return ea * eb;
  endfunction

  // Partial product i = |a| * (chunk i of |b|) * 2^(CH*i), negated when the signs differ.
  function automatic logic [PW-1:0] model_pp(input logic [XLEN-1:0] oa, ob, input logic os, input int i);
    logic [XLEN-1:0] ma, mb;
    logic [CH-1:0]   ch;
    logic [PW-1:0]   p;
    ma = (os && oa[XLEN-1]) ? (XLEN'(0) - oa) : oa;
    mb = (os && ob[XLEN-1]) ? (XLEN'(0) - ob) : ob;
    ch = CH'(mb >> (CH*i));
    p  = ({{XLEN{1'b0}}, ma} * {{(PW-CH){1'b0}}, ch}) << (CH*i);
    return (os && (oa[XLEN-1] ^ ob[XLEN-1])) ? (PW'(0) - p) : p;
  endfunction

  task automatic run_op(input logic [XLEN-1:0] oa, ob, input logic os, input int hold,
                        output logic [N*PW-1:0] got, output int lat);
    in_valid = 1'b1; a = oa; b = ob; is_signed = os; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    got = pp_out;
    repeat (hold) begin @(posedge clk); #1; end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (pp_out !== '0) begin bad++; $display("FAIL reset_pp_out got=%0h want=0", pp_out); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_unsigned();
    logic [N*PW-1:0] got;
    logic [PW-1:0]   want;
    int lat;
    run_op(64'd3, 64'd5, 1'b0, 0, got, lat);
    total++; if (lat !== 8) begin bad++; $display("FAIL u_latency got=%0d want=8", lat); end
    total++; if (pp_of(got, 0) !== 128'd15) begin bad++; $display("FAIL u_pp0 got=%0h want=f", pp_of(got, 0)); end
    for (int i = 1; i < N; i++) begin
      total++; if (pp_of(got, i) !== '0) begin bad++; $display("FAIL u_pp%0d got=%0h want=0", i, pp_of(got, i)); end
    end
    total++; if (sum_pp(got) !== 128'd15) begin bad++; $display("FAIL u_sum got=%0h want=f", sum_pp(got)); end

    run_op(64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 0, got, lat);
    for (int i = 0; i < N; i++) begin
      want = 128'hFF << (8*i);
      total++; if (pp_of(got, i) !== want) begin bad++; $display("FAIL ones_pp%0d got=%0h want=%0h", i, pp_of(got, i), want); end
    end
    total++;
    if (sum_pp(got) !== 128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF) begin
      bad++; $display("FAIL ones_sum got=%0h want=ffffffffffffffff", sum_pp(got));
    end
  endtask

  task automatic test_signed();
    logic [N*PW-1:0] got;
    logic [PW-1:0]   m15;
    int lat;
    m15 = {{120{1'b1}}, 8'hF1};
    run_op(64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 1'b1, 0, got, lat);
    total++; if (pp_of(got, 0) !== m15) begin bad++; $display("FAIL s_pp0 got=%0h want=%0h", pp_of(got, 0), m15); end
    for (int i = 1; i < N; i++) begin
      total++; if (pp_of(got, i) !== '0) begin bad++; $display("FAIL s_pp%0d got=%0h want=0", i, pp_of(got, i)); end
    end
    total++; if (sum_pp(got) !== m15) begin bad++; $display("FAIL s_sum got=%0h want=%0h", sum_pp(got), m15); end

    run_op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, 0, got, lat);
    total++;
    if (sum_pp(got) !== (128'd1 << 126)) begin
      bad++; $display("FAIL minmin_sum got=%0h want=%0h", sum_pp(got), 128'd1 << 126);
    end

    run_op(64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 0, got, lat);
    total++; if (got !== '0) begin bad++; $display("FAIL zero_neg got=%0h want=0", got); end
  endtask

  task automatic test_backpressure();
    logic [N*PW-1:0] cap;
    logic [XLEN-1:0] oa, ob;
    int lat;
    oa = 64'hFEDC_BA98_7654_3210;
    ob = 64'h0123_4567_89AB_CDEF;
    in_valid = 1'b1; a = oa; b = ob; is_signed = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_timeout got=%b want=1", out_valid); end
    cap = pp_out;
    total++;
    if (sum_pp(cap) !== ref_prod(oa, ob, 1'b1)) begin
      bad++; $display("FAIL bp_sum got=%0h want=%0h", sum_pp(cap), ref_prod(oa, ob, 1'b1));
    end
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1; a = {$urandom, $urandom}; b = {$urandom, $urandom};
      @(posedge clk); #1;
      total++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || pp_out !== cap) begin
        bad++; $display("FAIL bp_hold%0d got=%b%b want=10", k, out_valid, in_ready);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready got=%b want=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_release_valid got=%b want=0", out_valid); end
  endtask

  task automatic test_reset_mid_gen();
    logic [N*PW-1:0] got;
    int lat;
    int seen;
    in_valid = 1'b1; a = 64'h1234_5678_9ABC_DEF0; b = 64'hFFFF_0000_FFFF_0000; is_signed = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%b want=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL midrst_ready got=%b want=1", in_ready); end
    total++; if (pp_out !== '0) begin bad++; $display("FAIL midrst_pp got=%0h want=0", pp_out); end
    #3;
    rst_n = 1'b1;
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL midrst_no_output got=%0d want=0", seen); end
    run_op(64'hFFFF_FFFF_FFFF_FF85, 64'd1000, 1'b1, 1, got, lat);
    total++; if (lat !== 8) begin bad++; $display("FAIL midrst_latency got=%0d want=8", lat); end
    total++;
    if (sum_pp(got) !== ref_prod(64'hFFFF_FFFF_FFFF_FF85, 64'd1000, 1'b1)) begin
      bad++; $display("FAIL midrst_sum got=%0h want=%0h", sum_pp(got), ref_prod(64'hFFFF_FFFF_FFFF_FF85, 64'd1000, 1'b1));
    end
  endtask

  task automatic test_back_to_back();
    logic [N*PW-1:0] got;
    logic [XLEN-1:0] oa, ob;
    logic            os;
    int lat;
    int nbad_pp;
    for (int n = 0; n < 200; n++) begin
      oa = {$urandom, $urandom};
      ob = {$urandom, $urandom};
      case ($urandom_range(0, 7))
        0: oa = '0;
        1: ob = 64'h8000_0000_0000_0000;
        2: oa = '1;
        3: ob = 64'(($urandom_range(0, 255)));
        default: ;
      endcase
      os = 1'($urandom_range(0, 1));
      run_op(oa, ob, os, $urandom_range(0, 3), got, lat);
      total++; if (lat !== 8) begin bad++; $display("FAIL rnd%0d_latency got=%0d want=8", n, lat); end
      total++;
      if (sum_pp(got) !== ref_prod(oa, ob, os)) begin
        bad++; $display("FAIL rnd%0d_sum got=%0h want=%0h", n, sum_pp(got), ref_prod(oa, ob, os));
      end
      nbad_pp = 0;
      for (int i = 0; i < N; i++) if (pp_of(got, i) !== model_pp(oa, ob, os, i)) nbad_pp++;
      total++; if (nbad_pp !== 0) begin bad++; $display("FAIL rnd%0d_pp got=%0d_wrong want=0_wrong", n, nbad_pp); end
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        bad++; $display("FAIL rnd%0d_after got=%b%b want=01", n, out_valid, in_ready);
      end
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_unsigned();
    test_signed();
    test_backpressure();
    test_reset_mid_gen();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
